// File: rtl/xocc_dsa_cmd_endpoint.sv
// rtl/xocc_dsa_cmd_endpoint.sv - DSA-side XOCC queue endpoint: pops commands, dispatches EXEC, pushes responses
// Optional engine watchdog enabled by defining XOCC_DSA_TIMEOUT_EN.
module xocc_dsa_cmd_endpoint #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 xocc_clk,
    input  logic                 cpurst_b,
    input  logic                 empty_cmd,
    input  logic [31:0]          dsa_cmd_buffer,
    output logic                 rd_en_cmd,
    input  logic                 full_rsp,
    output logic                 wr_en_rsp,
    output logic [31:0]          dsa_rsp_buffer,
    output logic                 eng_req_vld,
    output logic [27:0]          eng_req_data,
    input  logic                 eng_req_rdy,
    input  logic                 eng_rsp_vld,
    input  logic [31:0]          eng_rsp_data,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] cmd_cnt,
    output logic [7:0]           err_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_EXEC = 4'h1;
    localparam logic [3:0] OP_ECHO = 4'h2;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    state_e               state_q, state_d;
    logic [31:0]          cmd_q, cmd_d;
    logic [31:0]          rsp_q, rsp_d;
    logic [CNT_WIDTH-1:0] cmd_cnt_q, cmd_cnt_d;
    logic [7:0]           err_cnt_q, err_cnt_d;
    logic                 err_inc;

`ifdef XOCC_DSA_TIMEOUT_EN
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] timer_q, timer_d;

    always_ff @(posedge xocc_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    always_ff @(posedge xocc_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            rsp_q     <= '0;
            cmd_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            rsp_q     <= rsp_d;
            cmd_cnt_q <= cmd_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rsp_d       = rsp_q;
        cmd_cnt_d   = cmd_cnt_q;
        err_inc     = 1'b0;
        rd_en_cmd   = 1'b0;
        wr_en_rsp   = 1'b0;
        eng_req_vld = 1'b0;
`ifdef XOCC_DSA_TIMEOUT_EN
        timer_d     = timer_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!empty_cmd) begin
                    rd_en_cmd = 1'b1;
                    cmd_d     = dsa_cmd_buffer;
                    cmd_cnt_d = cmd_cnt_q + 1'b1;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (cmd_q[31:28])
                    OP_NOP:  state_d = ST_IDLE;
                    OP_ECHO: begin
                        rsp_d   = cmd_q;
                        state_d = ST_RESP;
                    end
                    OP_EXEC: begin
                        state_d = ST_ISSUE;
`ifdef XOCC_DSA_TIMEOUT_EN
                        timer_d = '0;
`endif
                    end
                    default: begin
                        rsp_d   = {4'hE, cmd_q[27:0]};
                        err_inc = 1'b1;
                        state_d = ST_RESP;
                    end
                endcase
            end
            ST_ISSUE: begin
                eng_req_vld = 1'b1;
                if (eng_req_rdy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (eng_rsp_vld) begin
                    rsp_d   = eng_rsp_data;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                wr_en_rsp = ~full_rsp;
                if (!full_rsp) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef XOCC_DSA_TIMEOUT_EN
        // Expiry overrides ISSUE/WAIT unless the engine result lands this very cycle.
        if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
            timer_d = timer_q + 16'd1;
            if (timer_q == TIMER_LAST && !(state_q == ST_WAIT && eng_rsp_vld)) begin
                rsp_d       = {4'hD, cmd_q[27:0]};
                err_inc     = 1'b1;
                eng_req_vld = 1'b0;
                state_d     = ST_RESP;
            end
        end
`endif
        err_cnt_d = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    assign dsa_rsp_buffer = rsp_q;
    assign eng_req_data   = cmd_q[27:0];
    assign busy           = (state_q != ST_IDLE);
    assign cmd_cnt        = cmd_cnt_q;
    assign err_cnt        = err_cnt_q;

endmodule
